// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with a global-stall valid/ready handshake.
// Build option: define KSA_SATURATE_EN to clamp S on signed overflow; otherwise S wraps.
module ks_adder_pipe #(
    parameter int WIDTH      = 32,
    parameter int PIPE_EVERY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             v
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int PE     = (PIPE_EVERY > 0) ? PIPE_EVERY : 1;

    // Single stall signal for the whole pipe: bubbles are held, never collapsed.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Index l holds the G/P view after prefix level l (0 = input register).
    logic [WIDTH-1:0] g_o  [LEVELS+1];
    logic [WIDTH-1:0] p_o  [LEVELS+1];
    logic [WIDTH-1:0] p0_o [LEVELS+1];
    logic             c0_o [LEVELS+1];
    logic             vld_o[LEVELS+1];

    logic [WIDTH-1:0] y_eff;
    logic [WIDTH-1:0] g_r0, p_r0;
    logic             c0_r0, vld_r0;

    assign y_eff = sub ? ~y : y;

    // NOTE: only valid bits and outputs are reset; datapath registers load on a valid beat and need no reset.
    always_ff @(posedge clk) begin
        if (rst)      vld_r0 <= 1'b0;
        else if (adv) vld_r0 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            g_r0  <= x & y_eff;
            p_r0  <= x ^ y_eff;
            c0_r0 <= sub | cin;
        end
    end

    assign g_o[0]   = g_r0;
    assign p_o[0]   = p_r0;
    assign p0_o[0]  = p_r0;
    assign c0_o[0]  = c0_r0;
    assign vld_o[0] = vld_r0;

    for (genvar l = 1; l <= LEVELS; l++) begin : g_level
        localparam int D = 1 << (l - 1);
        logic [WIDTH-1:0] g_c, p_c;

        // Lanes with no partner D bits below pass G/P through unchanged.
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= D) begin : g_op
                assign g_c[i] = g_o[l-1][i] | (p_o[l-1][i] & g_o[l-1][i-D]);
                assign p_c[i] = p_o[l-1][i] & p_o[l-1][i-D];
            end else begin : g_pass
                assign g_c[i] = g_o[l-1][i];
                assign p_c[i] = p_o[l-1][i];
            end
        end

        if (PIPE_EVERY > 0 && l <= LEVELS - 1 && (l % PE) == 0) begin : g_reg
            logic [WIDTH-1:0] g_r, p_r, p0_r;
            logic             c0_r, vld_r;

            always_ff @(posedge clk) begin
                if (rst)      vld_r <= 1'b0;
                else if (adv) vld_r <= vld_o[l-1];
            end

            always_ff @(posedge clk) begin
                if (adv && vld_o[l-1]) begin
                    g_r  <= g_c;
                    p_r  <= p_c;
                    p0_r <= p0_o[l-1];
                    c0_r <= c0_o[l-1];
                end
            end

            assign g_o[l]   = g_r;
            assign p_o[l]   = p_r;
            assign p0_o[l]  = p0_r;
            assign c0_o[l]  = c0_r;
            assign vld_o[l] = vld_r;
        end else begin : g_comb
            assign g_o[l]   = g_c;
            assign p_o[l]   = p_c;
            assign p0_o[l]  = p0_o[l-1];
            assign c0_o[l]  = c0_o[l-1];
            assign vld_o[l] = vld_o[l-1];
        end
    end

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_w, s_d;
    logic             v_d;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        c    = '0;
        c[0] = c0_o[LEVELS];
        for (int i = 1; i <= WIDTH; i++) begin
            c[i] = g_o[LEVELS][i-1] | (p_o[LEVELS][i-1] & c0_o[LEVELS]);
        end
    end

    assign sum_w = p0_o[LEVELS] ^ c[WIDTH-1:0];
    assign v_d   = c[WIDTH] ^ c[WIDTH-1];

`ifdef KSA_SATURATE_EN
    // On overflow both operand signs agree and equal the carry out, so cout picks the rail.
    always_comb begin
        s_d = sum_w;
        if (v_d) s_d = c[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    assign s_d = sum_w;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
            v         <= 1'b0;
        end else if (adv) begin
            out_valid <= vld_o[LEVELS];
            if (vld_o[LEVELS]) begin
                s    <= s_d;
                cout <= c[WIDTH];
                v    <= v_d;
            end
        end
    end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Scoreboard bench for ks_adder_pipe: 32-bit PIPE_EVERY=2 instance plus 29-bit unpipelined instance.
module tb_ks_adder_pipe;

    localparam int WA    = 32;
    localparam int PA    = 2;
    localparam int WB    = 29;
    localparam int PB    = 0;
    localparam int LAT_A = 4;
    localparam int LAT_B = 2;

`ifdef KSA_SATURATE_EN
    localparam logic [31:0] OVF_POS_S = 32'h7FFF_FFFF;
    localparam logic [31:0] OVF_NEG_S = 32'h8000_0000;
`else
    localparam logic [31:0] OVF_POS_S = 32'h8000_0000;
    localparam logic [31:0] OVF_NEG_S = 32'h7FFF_FFFF;
`endif

    typedef struct packed {
        logic [63:0] s;
        logic        cout;
        logic        v;
    } res_t;

    logic clk, rst;

    logic          in_valid_a, in_ready_a, cin_a, sub_a, out_valid_a, out_ready_a, cout_a, v_a;
    logic [WA-1:0] x_a, y_a, s_a;
    logic          in_valid_b, in_ready_b, cin_b, sub_b, out_valid_b, out_ready_b, cout_b, v_b;
    logic [WB-1:0] x_b, y_b, s_b;

    res_t q_a[$];
    res_t q_b[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    ks_adder_pipe #(.WIDTH(WA), .PIPE_EVERY(PA)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .x(x_a), .y(y_a), .cin(cin_a), .sub(sub_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .s(s_a), .cout(cout_a), .v(v_a)
    );

    ks_adder_pipe #(.WIDTH(WB), .PIPE_EVERY(PB)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .x(x_b), .y(y_b), .cin(cin_b), .sub(sub_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .s(s_b), .cout(cout_b), .v(v_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference: plain integer add in w+1 bits, overflow from operand/result signs.
    function automatic res_t model(input int w, input logic [63:0] x, input logic [63:0] y,
                                   input logic cin, input logic sub);
        logic [63:0] mask, yy, full;
        logic        c0;
        res_t        r;
        mask   = (64'd1 << w) - 64'd1;
        yy     = sub ? (~y & mask) : (y & mask);
        c0     = sub ? 1'b1 : cin;
        full   = (x & mask) + yy + {63'd0, c0};
        r.s    = full & mask;
        r.cout = full[w];
        r.v    = (x[w-1] == yy[w-1]) && (r.s[w-1] != x[w-1]);
`ifdef KSA_SATURATE_EN
        if (r.v) r.s = x[w-1] ? (64'd1 << (w - 1)) : ((64'd1 << (w - 1)) - 64'd1);
`endif
        return r;
    endfunction

    logic        stall_a = 1'b0;
    logic [31:0] held_s_a;
    logic [1:0]  held_f_a;

    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            q_a.delete();
            stall_a = 1'b0;
        end else begin
            check("in_ready_a", 64'(in_ready_a), 64'(!(out_valid_a && !out_ready_a)));
            if (stall_a) begin
                check("hold_valid_a", 64'(out_valid_a), 64'd1);
                check("hold_s_a", 64'(s_a), 64'(held_s_a));
                check("hold_flags_a", 64'({cout_a, v_a}), 64'(held_f_a));
            end
            if (out_valid_a && out_ready_a) begin
                if (q_a.size() == 0) check("spurious_a", 64'(out_valid_a), 64'd0);
                else begin
                    e = q_a.pop_front();
                    check("s_a", 64'(s_a), e.s);
                    check("cout_a", 64'(cout_a), 64'(e.cout));
                    check("v_a", 64'(v_a), 64'(e.v));
                end
            end
            stall_a  = out_valid_a && !out_ready_a;
            held_s_a = s_a;
            held_f_a = {cout_a, v_a};
            if (in_valid_a && in_ready_a) q_a.push_back(model(WA, 64'(x_a), 64'(y_a), cin_a, sub_a));
        end
    end

    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            q_b.delete();
        end else begin
            check("in_ready_b", 64'(in_ready_b), 64'(!(out_valid_b && !out_ready_b)));
            if (out_valid_b && out_ready_b) begin
                if (q_b.size() == 0) check("spurious_b", 64'(out_valid_b), 64'd0);
                else begin
                    e = q_b.pop_front();
                    check("sum_b", 64'({cout_b, s_b}), 64'({e.cout, e.s[WB-1:0]}));
                    check("v_b", 64'(v_b), 64'(e.v));
                end
            end
            if (in_valid_b && in_ready_b) q_b.push_back(model(WB, 64'(x_b), 64'(y_b), cin_b, sub_b));
        end
    end

    task automatic run_a(input logic [31:0] x, input logic [31:0] y, input logic cin, input logic sub,
                         input logic [31:0] es, input logic ec, input logic ev, input string tag);
        int n;
        x_a = x; y_a = y; cin_a = cin; sub_a = sub;
        in_valid_a  = 1'b1;
        out_ready_a = 1'b1;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        n = 1;
        while (!out_valid_a && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(LAT_A));
        check({tag, "_s"}, 64'(s_a), 64'(es));
        check({tag, "_cout"}, 64'(cout_a), 64'(ec));
        check({tag, "_v"}, 64'(v_a), 64'(ev));
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int         i, cyc, n;
        logic       load;
        logic [3:0] pat;

        rst = 1'b1;
        in_valid_a = 1'b0; x_a = '0; y_a = '0; cin_a = 1'b0; sub_a = 1'b0; out_ready_a = 1'b1;
        in_valid_b = 1'b0; x_b = '0; y_b = '0; cin_b = 1'b0; sub_b = 1'b0; out_ready_b = 1'b1;
        in_valid_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready_a", 64'(in_ready_a), 64'd1);
        check("rst_out_valid_a", 64'(out_valid_a), 64'd0);
        check("rst_s_a", 64'(s_a), 64'd0);
        check("rst_flags_a", 64'({cout_a, v_a}), 64'd0);
        check("rst_out_valid_b", 64'(out_valid_b), 64'd0);
        in_valid_a = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_out_valid_a", 64'(out_valid_a), 64'd0);

        run_a(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "wrap");
        run_a(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_neg");
        run_a(32'd1234, 32'd1234, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, "sub_eq");
        run_a(32'd1, 32'd2, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b0, "cin");
        run_a(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, OVF_POS_S, 1'b0, 1'b1, "ovf_pos");
        run_a(32'h8000_0000, 32'd1, 1'b0, 1'b1, OVF_NEG_S, 1'b1, 1'b1, "ovf_neg");

        // 20 beats back to back while the consumer stalls in a 1,0,0,1 pattern.
        pat = 4'b1001;
        i = 0; cyc = 0; load = 1'b1;
        in_valid_a = 1'b1;
        while (i < 20 && cyc < 200) begin
            if (load) begin
                x_a = $urandom; y_a = $urandom;
                cin_a = 1'($urandom_range(0, 1)); sub_a = 1'($urandom_range(0, 1));
            end
            out_ready_a = pat[cyc % 4];
            @(negedge clk);
            load = in_ready_a;
            if (load) i++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        check("b2b_sent", 64'(i), 64'd20);
        repeat (LAT_A + 2) @(posedge clk);
        #1;
        check("b2b_drained", 64'(q_a.size()), 64'd0);

        // Three beats in flight, then a one-cycle reset with a beat offered.
        in_valid_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            x_a = $urandom; y_a = $urandom; cin_a = 1'b0; sub_a = 1'b0;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        x_a = 32'h1111_1111;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid_a = 1'b0;
        for (int k = 0; k < LAT_A + 2; k++) begin
            @(negedge clk);
            check("flush_out_valid", 64'(out_valid_a), 64'd0);
            check("flush_s", 64'(s_a), 64'd0);
        end

        // Unpipelined 29-bit instance: latency, then random traffic.
        @(posedge clk); #1;
        x_b = 29'h1FFF_FFFF; y_b = 29'd1; cin_b = 1'b0; sub_b = 1'b0;
        in_valid_b = 1'b1;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        n = 1;
        while (!out_valid_b && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("b_latency", 64'(n), 64'(LAT_B));
        check("b_wrap", 64'({cout_b, s_b}), 64'h2000_0000);
        @(posedge clk); #1;

        for (int k = 0; k < 10000; k++) begin
            in_valid_b = ($urandom_range(0, 3) != 0);
            x_b   = 29'($urandom);
            y_b   = 29'($urandom);
            cin_b = 1'($urandom_range(0, 1));
            sub_b = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid_b = 1'b0;
        repeat (LAT_B + 2) @(posedge clk);
        #1;
        check("b_drained", 64'(q_b.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
